pointer_pair_ctrl: RTL
======================

# pointer_pair_ctrl

Sequencer for the IP/DP pointer pair. It accepts one command at a time over a valid/ready handshake. It expands each command into the cycle-by-cycle active-low strobes, count enable, write data and selector the pointer pair needs: fetch, DP load/read, DP address output, role swap and jump. It sits between the instruction-control logic and the pointer pair, and owns the selector register.

## Interface
- FETCH_HOLD, default 1: cycles the IP address is driven before the count cycle; legal range 0..3.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd  in  3  opcode: 0 NOP, 1 FETCH, 2 LOAD_DP, 3 READ_DP, 4 ADDR_DP, 5 SWAP, 6 JUMP, 7 reserved.
- cmd_operand  in  16  immediate for LOAD_DP/JUMP; latched on accept.
- done  out  1  one-cycle pulse in the cycle after a command's last step.
- err  out  1  sticky; set by a reserved opcode, cleared only by rst.
- rd_data  out  16  result of the last READ_DP; holds until the next READ_DP.
- ptr_data_in  in  8  pointer-pair data output bus.
- ptr_di  out  8  pointer-pair write data.
- n_oe_addr_ip, n_oe_addr_dp, n_oe_dl, n_oe_dh  out  1 each  active-low output enables to the pointer pair.
- n_we_l, n_we_h  out  1 each  active-low write strobes to the pointer pair.
- cnt  out  1  IP count enable.
- selector  out  1  role select: 0 means register A is IP, 1 means register B is IP.

## Operation
- All pointer-facing outputs are registered (no combinational glitches on strobes). An output "in state S" is valid for the whole cycle the FSM is in S.
- Deasserted levels:
  - all n_* outputs = 1
  - cnt = 0
  - ptr_di = 0x00
- States and the strobes each asserts:
  - IDLE: none.
  - FA: n_oe_addr_ip=0.
  - FC: n_oe_addr_ip=0, cnt=1.
  - WL: n_we_l=0, ptr_di=op[7:0].
  - WH: n_we_h=0, ptr_di=op[15:8].
  - RL: n_oe_dl=0.
  - RH: n_oe_dh=0.
  - AD: n_oe_addr_dp=0.
  - SW: no strobes; selector toggles at the end of the cycle.
- Accept happens when cmd_valid & cmd_ready. cmd_ready = (state==IDLE) & ~rst.
- Sequences after accept:
  - NOP: IDLE.
  - FETCH: FA×FETCH_HOLD, then FC, then IDLE. IP increments at the end of FC.
  - LOAD_DP: WL → WH → IDLE.
  - READ_DP: RL → RH → IDLE.
    - rd_data[7:0] captures ptr_data_in at the end of RL.
    - rd_data[15:8] captures ptr_data_in at the end of RH.
  - ADDR_DP: AD → IDLE.
  - SWAP: SW → IDLE.
  - JUMP: WL → WH → SW → IDLE. The operand becomes the new IP; the old IP becomes DP.
  - Reserved (7): no strobes, err←1, done still pulses.
- done is asserted in the first IDLE cycle after the last step; for NOP/reserved, in the cycle after accept.
- A new command may be accepted in the same cycle done is high (back-to-back; one IDLE cycle between commands).
- Never asserted together: more than one address enable, any read enable together with any write strobe, or cnt outside FC.

## Timing
- Reset (rst high at a rising edge) produces the following on the next cycle, regardless of the current state:
  - state=IDLE
  - selector=0
  - all strobes deasserted
  - done=0, err=0
  - rd_data=0x0000
  - cmd_ready=1 once rst is low
- A command in progress is abandoned with no further strobes. Pointer contents are not restored; the pointer pair's own n_rst is driven as ~rst at top level.
- Latency from the accept edge to done, in cycles:
  - FETCH: FETCH_HOLD+2
  - LOAD_DP: 3
  - READ_DP: 3
  - ADDR_DP: 2
  - SWAP: 2
  - JUMP: 4
  - NOP/reserved: 1
- FETCH_HOLD=0: FETCH goes directly to FC, and the address and count are in the same cycle.
- The selector change is registered and takes effect in the cycle after SW. A FETCH accepted immediately after SWAP/JUMP uses the new IP.
- cmd and cmd_operand are ignored except at accept; changes during a command have no effect.
- IP wrap: counting 0xFFFF→0x0000 is the pointer pair's behaviour; the controller asserts cnt unconditionally.

## Test plan
- Reset then idle:
  - Checks: all n_* outputs=1, cnt=0, selector=0, cmd_ready=1, err=0.
  - Then hold cmd_valid=0 for 10 cycles; no strobes toggle.
- LOAD_DP 0xBEEF, then READ_DP:
  - WL sees ptr_di=0xEF, WH sees ptr_di=0xBE.
  - rd_data=0xBEEF when done pulses; done latencies are 3 and 3.
- IP reset 0x0000, FETCH ×3 (FETCH_HOLD=1):
  - Address strobe plus cnt patterns are observed.
  - IP reads 0x0003 after SWAP+READ_DP.
  - done latency is 3 each.
- JUMP 0x2000, then FETCH:
  - selector=1 afterwards.
  - The FETCH asserts n_oe_addr_ip with register B supplying address 0x2000.
  - A READ_DP returns the old IP.
- rst asserted during the WH cycle of JUMP 0x1234:
  - Next cycle: IDLE, all strobes deasserted, selector=0.
  - No SW step occurs; no done pulse.
- Issue cmd=7 followed back-to-back by ADDR_DP:
  - err=1 and stays 1.
  - done pulses for both commands.
  - ADDR_DP asserts n_oe_addr_dp for exactly one cycle.

Source files
------------

// File: rtl/pointer_pair_ctrl.sv
// Command sequencer for the IP/DP pointer pair.
// Expands one command at a time into registered strobes and owns the selector.
module pointer_pair_ctrl #(
  parameter int unsigned FETCH_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd,
  input  logic [15:0] cmd_operand,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_data,
  input  logic [7:0]  ptr_data_in,
  output logic [7:0]  ptr_di,
  output logic        n_oe_addr_ip,
  output logic        n_oe_addr_dp,
  output logic        n_oe_dl,
  output logic        n_oe_dh,
  output logic        n_we_l,
  output logic        n_we_h,
  output logic        cnt,
  output logic        selector
);

  typedef enum logic [3:0] {
    S_IDLE, S_FA, S_FC, S_WL, S_WH,
    S_RL, S_RH, S_AD, S_SW
  } state_e;

  localparam logic [1:0] HOLD_INIT =
    (FETCH_HOLD == 0) ? 2'd0 : 2'(FETCH_HOLD - 1);

  // {ip, dp, dl, dh, we_l, we_h, cnt}
  localparam logic [6:0] STRB_OFF = 7'b1111110;

  state_e      state_q, state_d;
  logic [1:0]  hold_q, hold_d;
  logic [15:0] op_q, op_d;
  logic        jump_q, jump_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        sel_q;
  logic [15:0] rd_q;
  logic [6:0]  strb_q, strb_d;
  logic [7:0]  di_q, di_d;
  logic        accept;

  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    jump_d  = jump_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_operand;
          jump_d = 1'b0;
          unique case (cmd)
            3'd1: begin
              if (FETCH_HOLD == 0) begin
                state_d = S_FC;
              end else begin
                state_d = S_FA;
                hold_d  = HOLD_INIT;
              end
            end
            3'd2: state_d = S_WL;
            3'd3: state_d = S_RL;
            3'd4: state_d = S_AD;
            3'd5: state_d = S_SW;
            3'd6: begin
              state_d = S_WL;
              jump_d  = 1'b1;
            end
            3'd7: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_FA: begin
        if (hold_q == 2'd0) state_d = S_FC;
        else hold_d = hold_q - 2'd1;
      end
      S_WL: state_d = S_WH;
      S_WH: begin
        // JUMP writes the operand into DP, then swaps it into the IP role
        if (jump_q) begin
          state_d = S_SW;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_RL: state_d = S_RH;
      S_FC, S_RH, S_AD, S_SW: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register in step with it
  always_comb begin
    strb_d = STRB_OFF;
    di_d   = 8'h00;
    unique case (state_d)
      S_FA: strb_d = 7'b0111110;
      S_FC: strb_d = 7'b0111111;
      S_WL: begin
        strb_d = 7'b1111010;
        di_d   = op_d[7:0];
      end
      S_WH: begin
        strb_d = 7'b1111100;
        di_d   = op_d[15:8];
      end
      S_RL: strb_d = 7'b1101110;
      S_RH: strb_d = 7'b1110110;
      S_AD: strb_d = 7'b1011110;
      default: strb_d = STRB_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= 2'd0;
      op_q    <= 16'h0000;
      jump_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      rd_q    <= 16'h0000;
      strb_q  <= STRB_OFF;
      di_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      jump_q  <= jump_d;
      err_q   <= err_d;
      done_q  <= done_d;
      strb_q  <= strb_d;
      di_q    <= di_d;
      if (state_q == S_SW) sel_q <= ~sel_q;
      if (state_q == S_RL) rd_q[7:0] <= ptr_data_in;
      if (state_q == S_RH) rd_q[15:8] <= ptr_data_in;
    end
  end

  assign n_oe_addr_ip = strb_q[6];
  assign n_oe_addr_dp = strb_q[5];
  assign n_oe_dl      = strb_q[4];
  assign n_oe_dh      = strb_q[3];
  assign n_we_l       = strb_q[2];
  assign n_we_h       = strb_q[1];
  assign cnt          = strb_q[0];
  assign ptr_di       = di_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rd_data      = rd_q;
  assign selector     = sel_q;

endmodule
